fifo_uart_tx: RTL and testbench

//   Reader end of the byte FIFO: drains queued words and serialises each one as a UART frame.
//   A frame is one start bit, W data bits LSB first, then STOP_BITS stop bits; there is no parity.

---
 rtl/fifo_uart_tx.sv | 120 ++++++++++++
 tb/tb_fifo_uart_tx.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// Drains a byte FIFO and serialises each word as a UART frame: start bit, W data bits LSB first, STOP_BITS stop bits.
// tx falls two edges after IDLE sees enable & ~fifo_empty; at most one pop per frame and none while the frame is on the line.
module fifo_uart_tx #(
   parameter int W            = 8,
   parameter int CLKS_PER_BIT = 434,
   parameter int STOP_BITS    = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         enable,
   input  logic         fifo_empty,
   input  logic [W-1:0] fifo_data,
   output logic         fifo_re,
   output logic         tx,
   output logic         busy,
   output logic         frame_done
);
   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BW = $clog2(W) + 1;
   localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] BAUD_PRE  = CW'(CLKS_PER_BIT - 2);
   localparam logic [BW-1:0] BIT_LAST  = BW'(W - 1);
   localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

   typedef enum logic [2:0] {IDLE, FETCH, LOAD, START, DATA, STOP} state_t;

   state_t        state;
   logic [CW-1:0] baud_cnt;
   logic [BW-1:0] bit_cnt;
   logic [W-1:0]  shift_reg;
   logic          baud_end;

   assign baud_end = (baud_cnt == BAUD_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         baud_cnt   <= '0;
         bit_cnt    <= '0;
         shift_reg  <= '0;
         fifo_re    <= 1'b0;
         tx         <= 1'b1;
         busy       <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         fifo_re    <= 1'b0;
         frame_done <= 1'b0;
         case (state)
            IDLE: begin
               tx       <= 1'b1;
               busy     <= 1'b0;
               baud_cnt <= '0;
               bit_cnt  <= '0;
               if (enable && !fifo_empty) begin
                  state   <= FETCH;
                  fifo_re <= 1'b1;
                  busy    <= 1'b1;
               end
            end
            FETCH: state <= LOAD;
            // The FIFO popped at the edge ending FETCH, so fifo_data is valid now.
            LOAD: begin
               shift_reg <= fifo_data;
               tx        <= 1'b0;
               state     <= START;
            end
            START: begin
               if (baud_end) begin
                  baud_cnt <= '0;
                  bit_cnt  <= '0;
                  tx       <= shift_reg[0];
                  state    <= DATA;
               end else begin
                  baud_cnt <= baud_cnt + CW'(1);
               end
            end
            DATA: begin
               if (baud_end) begin
                  baud_cnt <= '0;
                  if (bit_cnt == BIT_LAST) begin
                     bit_cnt <= '0;
                     tx      <= 1'b1;
                     state   <= STOP;
                  end else begin
                     shift_reg <= shift_reg >> 1;
                     tx        <= shift_reg[1];
                     bit_cnt   <= bit_cnt + BW'(1);
                  end
               end else begin
                  baud_cnt <= baud_cnt + CW'(1);
               end
            end
            STOP: begin
               // Registered pulse: raise it one cycle early so it covers the final stop cycle.
               if (bit_cnt == STOP_LAST && baud_cnt == BAUD_PRE)
                  frame_done <= 1'b1;
               if (baud_end) begin
                  baud_cnt <= '0;
                  if (bit_cnt == STOP_LAST) begin
                     bit_cnt <= '0;
                     busy    <= 1'b0;
                     state   <= IDLE;
                  end else begin
                     bit_cnt <= bit_cnt + BW'(1);
                  end
               end else begin
                  baud_cnt <= baud_cnt + CW'(1);
               end
            end
            default: begin
               state    <= IDLE;
               tx       <= 1'b1;
               busy     <= 1'b0;
               baud_cnt <= '0;
               bit_cnt  <= '0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: shared FIFO model feeding a 1-stop and a 2-stop instance, scoreboard monitor on the serial line.
module tb_fifo_uart_tx;
   logic       clk, rst_n;
   logic       en1, en2;
   logic       fifo_empty;
   logic [7:0] fifo_data;
   logic       fifo_re1, tx1, busy1, fd1;
   logic       fifo_re2, tx2, busy2, fd2;

   int         n_checks = 0;
   int         n_fail = 0;
   logic [7:0] fq[$];
   logic [7:0] exp_q[$];
   int         re_cnt = 0;
   logic       prev_re = 1'b0;
   logic       sel = 1'b0;
   logic       mon_en = 1'b1;
   logic       mon_busy = 1'b0;
   int         frames = 0;
   int         gap_cnt = 0;
   int         last_gap = -1;

   fifo_uart_tx #(.W(8), .CLKS_PER_BIT(4), .STOP_BITS(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .enable(en1), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
      .fifo_re(fifo_re1), .tx(tx1), .busy(busy1), .frame_done(fd1));

   fifo_uart_tx #(.W(8), .CLKS_PER_BIT(4), .STOP_BITS(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .enable(en2), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
      .fifo_re(fifo_re2), .tx(tx2), .busy(busy2), .frame_done(fd2));

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic push_word(input logic [7:0] b, input bit expect_frame);
      fq.push_back(b);
      fifo_empty = (fq.size() == 0);
      if (expect_frame) exp_q.push_back(b);
   endtask

   task automatic wait_idle(input int bound);
      int n = 0;
      while ((exp_q.size() != 0 || mon_busy || busy1 || busy2) && n < bound) begin
         @(negedge clk);
         n++;
      end
      check("wait_idle_in_time", (n < bound) ? 1 : 0, 1);
   endtask

   // FIFO model: pops on the cycle fifo_re is high, data is ready before LOAD ends.
   always @(negedge clk) begin
      if (fifo_re1 || fifo_re2) begin
         re_cnt++;
         check("pop_nonempty", (fq.size() != 0) ? 1 : 0, 1);
         check("re_single_cycle", int'(prev_re), 0);
         if (fq.size() != 0) fifo_data = fq.pop_front();
         fifo_empty = (fq.size() == 0);
      end
      prev_re = fifo_re1 | fifo_re2;
   end

   // Serial-line monitor: captures a frame from its first low sample and compares with the scoreboard.
   initial begin : monitor
      logic       prev_tx, cur_tx, s, f, exp_bit;
      logic [7:0] exp_b, got;
      int         nsamp, mism, fd_pos, fd_cnt;
      prev_tx = 1'b1;
      forever begin
         @(negedge clk);
         cur_tx = sel ? tx2 : tx1;
         if (mon_en && prev_tx && !cur_tx) begin
            mon_busy = 1'b1;
            last_gap = gap_cnt;
            nsamp    = (9 + (sel ? 2 : 1)) * 4;
            check("frame_expected", (exp_q.size() != 0) ? 1 : 0, 1);
            exp_b  = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
            got    = 8'h00;
            mism   = 0;
            fd_pos = -1;
            fd_cnt = 0;
            for (int i = 0; i < nsamp; i++) begin
               if (i > 0) @(negedge clk);
               s = sel ? tx2 : tx1;
               f = sel ? fd2 : fd1;
               if (i < 4) exp_bit = 1'b0;
               else if (i < 36) exp_bit = exp_b[(i - 4) / 4];
               else exp_bit = 1'b1;
               if (s !== exp_bit) mism++;
               if (i >= 4 && i < 36 && (i % 4) == 2) got[(i - 4) / 4] = s;
               if (f) begin
                  fd_cnt++;
                  fd_pos = i;
               end
            end
            check("frame_byte", int'(got), int'(exp_b));
            check("frame_wave_mismatches", mism, 0);
            check("frame_done_pos", fd_pos, nsamp - 1);
            check("frame_done_count", fd_cnt, 1);
            frames++;
            gap_cnt  = 0;
            prev_tx  = 1'b1;
            mon_busy = 1'b0;
         end else begin
            if (cur_tx) gap_cnt++;
            prev_tx = cur_tx;
         end
      end
   end

   initial begin
      int n, re0, f0, bad;
      clk = 1'b0; rst_n = 1'b0; en1 = 1'b0; en2 = 1'b0;
      fifo_empty = 1'b1; fifo_data = 8'h00;
      #12;
      check("rst_tx", int'(tx1), 1);
      check("rst_busy", int'(busy1), 0);
      check("rst_fifo_re", int'(fifo_re1), 0);
      check("rst_frame_done", int'(fd1), 0);
      check("rst_tx2", int'(tx2), 1);
      @(negedge clk); rst_n = 1'b1;

      // Async reset in the middle of data bit 1 of 0xA5 (a low bit).
      mon_en = 1'b0;
      push_word(8'hA5, 1'b0);
      en1 = 1'b1;
      n = 0;
      while (tx1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("t1_start_seen", int'(tx1), 0);
      repeat (9) @(negedge clk);
      check("t1_pre_reset_tx", int'(tx1), 0);
      #2 rst_n = 1'b0;
      #1;
      check("t1_async_tx", int'(tx1), 1);
      check("t1_async_busy", int'(busy1), 0);
      check("t1_async_fifo_re", int'(fifo_re1), 0);
      @(negedge clk); rst_n = 1'b1;
      mon_en = 1'b1;
      re0 = re_cnt;
      bad = 0;
      repeat (20) begin
         @(negedge clk);
         if (!tx1 || busy1) bad++;
      end
      check("t1_quiet_after_reset", bad, 0);
      check("t1_no_pop_after_reset", re_cnt - re0, 0);

      // Single word 0xA5.
      re0 = re_cnt; f0 = frames;
      push_word(8'hA5, 1'b1);
      wait_idle(200);
      check("t2_pops", re_cnt - re0, 1);
      check("t2_frames", frames - f0, 1);

      // Back-to-back 0x00, 0xFF.
      re0 = re_cnt; f0 = frames;
      push_word(8'h00, 1'b1);
      push_word(8'hFF, 1'b1);
      wait_idle(300);
      check("t3_pops", re_cnt - re0, 2);
      check("t3_frames", frames - f0, 2);
      check("t3_gap_cycles", last_gap, 3);

      // enable gating and drop mid-frame.
      en1 = 1'b0;
      re0 = re_cnt; f0 = frames;
      push_word(8'h3C, 1'b1);
      bad = 0;
      repeat (20) begin
         @(negedge clk);
         if (!tx1 || busy1) bad++;
      end
      check("t4_disabled_quiet", bad, 0);
      check("t4_disabled_no_pop", re_cnt - re0, 0);
      en1 = 1'b1;
      n = 0;
      while (!busy1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("t4_busy_seen", int'(busy1), 1);
      repeat (15) @(negedge clk);
      en1 = 1'b0;
      push_word(8'h55, 1'b0);
      wait_idle(200);
      repeat (20) @(negedge clk);
      check("t4_pops", re_cnt - re0, 1);
      check("t4_frames", frames - f0, 1);
      check("t4_word_left", fq.size(), 1);
      check("t4_idle_tx", int'(tx1), 1);
      fq.delete();
      fifo_empty = 1'b1;

      // Two stop bits, 0x81.
      sel = 1'b1;
      re0 = re_cnt; f0 = frames;
      push_word(8'h81, 1'b1);
      en2 = 1'b1;
      wait_idle(200);
      check("t5_pops", re_cnt - re0, 1);
      check("t5_frames", frames - f0, 1);
      en2 = 1'b0;

      // Empty FIFO with both enabled.
      sel = 1'b0;
      en1 = 1'b1; en2 = 1'b1;
      re0 = re_cnt;
      bad = 0;
      repeat (1000) begin
         @(negedge clk);
         if (fifo_re1 || fifo_re2 || busy1 || busy2 || !tx1 || !tx2) bad++;
      end
      check("t6_empty_quiet", bad, 0);
      check("t6_no_pop", re_cnt - re0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
